// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for a multi-cycle RV32I core sharing one memory port.
// Optional perf counters: define MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  halted,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt,
`endif
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b;
  logic       is_r, is_i, is_lw, is_sw, is_br;
  logic       is_jal, is_jalr, is_lui;
  logic       alu_ok, legal, taken, mem_wait, to_hit;
  logic [2:0] alu_f, alu_x;
  logic       src_x;
  logic [1:0] imm_x;
  logic       unused_ok;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign f7b = instr[30];
  assign unused_ok = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    is_r    = (op == OP_R);
    is_i    = (op == OP_I);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_br   = (op == OP_BR);
    is_jal  = (op == OP_JAL);
    is_jalr = (op == OP_JALR);
    is_lui  = (op == OP_LUI);
    alu_f   = ALU_ADD;
    alu_ok  = 1'b1;
    unique case (f3)
      3'b000:  alu_f = (is_r && f7b) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_f = ALU_SLT;
      3'b110:  alu_f = ALU_OR;
      3'b111:  alu_f = ALU_AND;
      default: alu_ok = 1'b0;
    endcase
    legal = ((is_r || is_i) && alu_ok)
         || ((is_lw || is_sw) && f3 == 3'b010)
         || (is_br && f3[2:1] == 2'b00)
         || (is_jalr && f3 == 3'b000)
         || is_jal || is_lui;
    imm_x = 2'b00;
    alu_x = ALU_ADD;
    src_x = 1'b1;
    unique case (1'b1)
      is_r:    begin alu_x = alu_f; src_x = 1'b0; end
      is_i:    alu_x = alu_f;
      is_sw:   imm_x = 2'b01;
      is_br:   begin imm_x = 2'b10; alu_x = ALU_SUB; src_x = 1'b0; end
      is_jal:  imm_x = 2'b11;
      default: ;
    endcase
    taken = f3[0] ? !EQ : EQ;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'b00;
    ResultSrc = 2'b00;
    ALUctrl   = ALU_ADD;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    halted    = 1'b0;
    // to_hit: this wait cycle is the one that brings the count to MEM_TIMEOUT
    mem_wait  = 1'b0;
    to_hit    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          mem_wait = 1'b1;
          to_hit   = (cnt_q == TO_LAST);
        end
      end
      S_DECODE: begin
        ImmSrc  = imm_x;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        ImmSrc  = imm_x;
        ALUctrl = alu_x;
        ALUsrc  = src_x;
        if (is_br) begin
          pc_en   = 1'b1;
          pc_sel  = taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ImmSrc   = imm_x;
        ALUsrc   = 1'b1;
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        mem_we   = is_sw;
        MemWrite = is_sw;
        if (mem_ready) begin
          pc_en   = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end else begin
          mem_wait = 1'b1;
          to_hit   = (cnt_q == TO_LAST);
        end
      end
      S_WB: begin
        ImmSrc   = imm_x;
        ALUctrl  = alu_x;
        ALUsrc   = src_x;
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        pc_sel   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        ResultSrc = (is_jal || is_jalr) ? 2'd2
                  : is_lw  ? 2'd1
                  : is_lui ? 2'd3 : 2'd0;
        state_d  = S_FETCH;
      end
      default: begin
        halted  = 1'b1;
        state_d = S_TRAP;
      end
    endcase
    if (to_hit) state_d = S_TRAP;
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
      cnt_d = '0;
    else if (mem_wait)
      cnt_d = cnt_q + 1'b1;
    // everything quiet while reset is held, including the FETCH request
    if (!rst_n) begin
      mem_req  = 1'b0;
      AdrSrc   = 1'b0;
      IRWrite  = 1'b0;
      mem_we   = 1'b0;
      MemWrite = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (pc_en) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
// Perf-counter checks compile in with MULTICYCLE_PERF_CNT_EN.
module tb_multicycle_ctrl;

  logic        clk, rst_n, EQ, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, AdrSrc, IRWrite, pc_en;
  logic [1:0]  pc_sel, ResultSrc, ImmSrc;
  logic [2:0]  ALUctrl, state;
  logic        ALUsrc, RegWrite, MemWrite, halted;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_ADDI = 32'h00508193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_LUI  = 32'h123451B7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .pc_en(pc_en),
    .pc_sel(pc_sel), .ResultSrc(ResultSrc), .ALUctrl(ALUctrl),
    .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .halted(halted),
`ifdef MULTICYCLE_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    EQ = 1'b0;
    instr = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH until FETCH/TRAP, tallying controls.
  task automatic run(input logic [31:0] ins, input int waits,
                     input logic eq, output int cyc, output int npc,
                     output int nrw, output int nadr, output int nir,
                     output logic [1:0] sel, output logic [1:0] rs,
                     output logic [2:0] alu, output logic asrc);
    int waited = 0;
    instr = ins;
    EQ = eq;
    cyc = 0; npc = 0; nrw = 0; nadr = 0; nir = 0;
    sel = 2'd0; rs = 2'd0; alu = 3'd7; asrc = 1'b0;
    do begin
      if (state == 3'd3 && waited < waits) begin
        mem_ready = 1'b0;
        waited++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      nir += int'(IRWrite);
      nadr += int'(AdrSrc);
      if (pc_en) begin npc++; sel = pc_sel; end
      if (RegWrite) begin
        nrw++; rs = ResultSrc; alu = ALUctrl; asrc = ALUsrc;
      end
      @(negedge clk);
    end while (state != 3'd0 && state != 3'd5 && cyc < 50);
  endtask

  int cyc, npc, nrw, nadr, nir, n;
  logic [1:0] sel, rs;
  logic [2:0] alu;
  logic asrc;

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    EQ = 1'b0;
    instr = I_ADD;
    @(negedge clk);
    check("reset_outs", {15'd0, mem_req, mem_we, AdrSrc, IRWrite, pc_en,
          pc_sel, ResultSrc, ALUctrl, ALUsrc, ImmSrc, RegWrite,
          MemWrite, halted}, 32'd0);
    check("reset_state", {29'd0, state}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("fetch_req", {31'd0, mem_req}, 32'd1);

    run(I_ADD, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("add_cyc", cyc, 4);
    check("add_pcen", npc, 1);
    check("add_rw", nrw, 1);
    check("add_ir", nir, 1);
    check("add_ctl", {27'd0, alu, asrc, rs}, {27'd0, 3'b000, 1'b0, 2'd0});

    run(I_SUB, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("sub_alu", {29'd0, alu}, 32'd1);

    run(I_ADDI, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("addi_cyc_src", {cyc[15:0], 15'd0, asrc}, {16'd4, 16'd1});

    run(I_LW, 3, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("lw_cyc", cyc, 8);
    check("lw_adr", nadr, 4);
    check("lw_wb", {nrw[15:0], 14'd0, rs}, {16'd1, 16'd1});

    run(I_LW, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("lw0_cyc", cyc, 5);

    run(I_SW, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("sw_cyc", cyc, 4);
    check("sw_pc_rw", {npc[15:0], nrw[15:0]}, {16'd1, 16'd0});

    run(I_BEQ, 0, 1'b1, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("beq_t", {cyc[7:0], npc[7:0], nrw[7:0], 6'd0, sel},
          {8'd3, 8'd1, 8'd0, 8'd1});
    run(I_BEQ, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("beq_nt", {cyc[7:0], npc[7:0], nrw[7:0], 6'd0, sel},
          {8'd3, 8'd1, 8'd0, 8'd0});
    run(I_BNE, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("bne_t", {30'd0, sel}, 32'd1);

    run(I_JAL, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("jal", {cyc[7:0], 20'd0, sel, rs}, {8'd4, 20'd0, 2'd1, 2'd2});
    run(I_JALR, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("jalr", {cyc[7:0], 20'd0, sel, rs}, {8'd4, 20'd0, 2'd2, 2'd2});
    run(I_LUI, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("lui", {cyc[7:0], 20'd0, sel, rs}, {8'd4, 20'd0, 2'd0, 2'd3});

    run(I_ILL, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("ill_cyc", cyc, 2);
    check("ill_en", {npc[15:0], nrw[15:0]}, 32'd0);
    check("ill_trap", {28'd0, halted, state}, {28'd0, 1'b1, 3'd5});

    reset_dut();
    run(I_SLL, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("f3_trap", {29'd0, state}, 32'd5);

    reset_dut();
    mem_ready = 1'b0;
    n = 0;
    while (state == 3'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 15);
    check("to_trap", {28'd0, halted, state}, {28'd0, 1'b1, 3'd5});
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("trap_hold", {26'd0, mem_req, pc_en, halted, state},
          {26'd0, 1'b0, 1'b0, 1'b1, 3'd5});
    reset_dut();
    #1;
    check("trap_clr", {28'd0, halted, state}, 32'd0);

    instr = I_SW;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_mem", {27'd0, state, mem_req, mem_we, MemWrite},
          {27'd0, 3'd3, 1'b1, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("rst_drop", {28'd0, mem_req, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_fetch", {27'd0, mem_req, AdrSrc, state},
          {27'd0, 1'b1, 1'b0, 3'd0});
    run(I_ADD, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("post_rst_add", cyc, 4);

`ifdef MULTICYCLE_PERF_CNT_EN
    reset_dut();
    repeat (3)
      run(I_ADD, 0, 1'b0, cyc, npc, nrw, nadr, nir, sel, rs, alu, asrc);
    check("instret", instret_cnt, 32'd3);
    check("cycles", cycle_cnt, 32'd12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
